// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N requesters.
// Fixed non-pipelined sequence IDLE -> EXEC -> DONE; operands latched at grant.
module adder_share_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req,
    input  logic [N*WIDTH-1:0]   i_op_a,
    input  logic [N*WIDTH-1:0]   i_op_b,
    output logic [N-1:0]         o_grant,
    output logic [N-1:0]         o_done,
    output logic [WIDTH-1:0]     o_sum,
    output logic                 o_carry_out,
    output logic                 o_busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   r_idx, w_idx_nxt;
    logic [N-1:0]       r_grant, w_grant_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [WIDTH-1:0]   r_sum, w_sum_nxt;
    logic               r_carry, w_carry_nxt;

    logic [PTR_W-1:0]   w_pick;
    logic [PTR_W-1:0]   w_scan;
    logic               w_found;
    int                 w_scan_int;
    logic [N-1:0]       w_onehot;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH:0]     w_add;

    // The shared adder only ever sees the latched operands.
    assign w_add = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_found    = 1'b0;
        w_pick     = r_ptr;
        w_scan     = r_ptr;
        w_scan_int = 0;
        for (int k = 0; k < N; k++) begin
            w_scan_int = int'(r_ptr) + k;
            if (w_scan_int >= N) begin
                w_scan_int = w_scan_int - N;
            end
            w_scan = PTR_W'(w_scan_int);
            if (!w_found && i_req[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick == PTR_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_a     = i_op_a[i*WIDTH +: WIDTH];
                w_sel_b     = i_op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_grant <= w_grant_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_grant_nxt = r_grant;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_carry_nxt = r_carry;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_onehot;
                    w_idx_nxt   = w_pick;
                    w_a_nxt     = w_sel_a;
                    w_b_nxt     = w_sel_b;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                {w_carry_nxt, w_sum_nxt} = w_add;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_idx == PTR_W'(N-1)) ? '0 : r_idx + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Done is derived from registered state only, so it cannot glitch on Req.
    assign o_done      = (r_state == S_DONE) ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_sum       = r_sum;
    assign o_carry_out = r_carry;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed requests push expected
// results; a negedge monitor pops and compares whenever Done pulses.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 24;

    logic             clk = 1'b0;
    logic             rstN;
    logic [N-1:0]     req;
    logic [N*W-1:0]   opA;
    logic [N*W-1:0]   opB;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [W-1:0]     sum;
    logic             carry;
    logic             busy;

    typedef struct {
        int         idx;
        logic [W-1:0] sum;
        logic       carry;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   doneCycles[$];
    int   doneCount = 0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    adder_share_arbiter #(.N(N), .WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req       (req),
        .i_op_a      (opA),
        .i_op_b      (opB),
        .o_grant     (grant),
        .o_done      (done),
        .o_sum       (sum),
        .o_carry_out (carry),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input int idx, input logic [W-1:0] s, input logic c);
        exp_t e;
        e.idx   = idx;
        e.sum   = s;
        e.carry = c;
        expQ.push_back(e);
    endtask

    task automatic setOperands(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opA[i*W +: W] = a;
        opB[i*W +: W] = b;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
        checkOutput({tag, "_done"},  32'(done),  32'd0);
        checkOutput({tag, "_sum"},   32'(sum),   32'd0);
        checkOutput({tag, "_carry"}, 32'(carry), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    // Holds each masked requester high until it has received opsEach Dones,
    // dropping it in the cycle right after its final Done.
    task automatic applyStimulus(input logic [N-1:0] mask, input int opsEach, input int budget);
        int remaining[N];
        int left;
        logic [N-1:0] seen;
        left = 0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = mask[i] ? opsEach : 0;
            left += remaining[i];
        end
        req = mask;
        for (int c = 0; c < budget && left > 0; c++) begin
            @(negedge clk);
            seen = done;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (seen[i] && remaining[i] > 0) begin
                    remaining[i]--;
                    left--;
                    if (remaining[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (left > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: %0d ops outstanding, required 0", left);
            req = '0;
        end
    endtask

    always @(negedge clk) begin
        if (rstN === 1'b1 && done !== '0) begin
            doneCount++;
            doneCycles.push_back(cycle);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got %0h, required none", done);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("done",      32'(done),  32'(1) << monExp.idx);
                checkOutput("grantDone", 32'(grant), 32'(1) << monExp.idx);
                checkOutput("sum",       32'(sum),   32'(monExp.sum));
                checkOutput("carry",     32'(carry), 32'(monExp.carry));
                checkOutput("busyDone",  32'(busy),  32'd1);
            end
        end
    end

    initial begin
        int startCount;
        rstN = 1'b0;
        req  = '0;
        opA  = '0;
        opB  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rstN = 1'b1;

        // T1: single request, latency check
        setOperands(0, 24'd5, 24'd5);
        pushExp(0, 24'd10, 1'b0);
        req = 4'b0001;
        @(posedge clk);
        #1;
        checkOutput("t1GrantLatency", 32'(grant), 32'h1);
        checkOutput("t1BusyExec",     32'(busy),  32'd1);
        checkOutput("t1NoEarlyDone",  32'(done),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("t1DoneLatency",  32'(done),  32'h1);
        @(posedge clk);
        #1;
        req = '0;
        checkOutput("t1GrantIdle",    32'(grant), 32'd0);
        checkOutput("t1BusyIdle",     32'(busy),  32'd0);
        checkOutput("t1SumHeld",      32'(sum),   32'd10);

        // T2: carry out of the top bit, then a plain add
        setOperands(1, 24'hFFFFFF, 24'd1);
        pushExp(1, 24'd0, 1'b1);
        applyStimulus(4'b0010, 1, 20);
        setOperands(1, 24'd756, 24'd862);
        pushExp(1, 24'd1618, 1'b0);
        applyStimulus(4'b0010, 1, 20);

        // T3: two held requests from Ptr=0, then probe Ptr=3
        doReset();
        setOperands(0, 24'd100, 24'd23);
        setOperands(2, 24'h800000, 24'h800000);
        pushExp(0, 24'd123, 1'b0);
        pushExp(2, 24'd0, 1'b1);
        applyStimulus(4'b0101, 1, 30);
        setOperands(3, 24'd7, 24'd8);
        setOperands(0, 24'd1, 24'd2);
        pushExp(3, 24'd15, 1'b0);
        pushExp(0, 24'd3, 1'b0);
        applyStimulus(4'b1001, 1, 30);

        // T4: all four held for 12 ops
        doReset();
        for (int i = 0; i < N; i++) begin
            setOperands(i, W'(1000 * (i + 1)), W'(7 * (i + 1)));
        end
        for (int k = 0; k < 12; k++) begin
            pushExp(k % N, W'(1007 * ((k % N) + 1)), 1'b0);
        end
        doneCycles.delete();
        applyStimulus(4'b1111, 3, 100);
        checkOutput("t4DoneCount", 32'(doneCycles.size()), 32'd12);
        for (int k = 1; k < doneCycles.size(); k++) begin
            checkOutput("t4DoneSpacing", 32'(doneCycles[k] - doneCycles[k-1]), 32'd3);
        end

        // T6: requester drops Req during EXEC
        setOperands(2, 24'd205, 24'd192);
        pushExp(2, 24'd397, 1'b0);
        startCount = doneCount;
        req = 4'b0100;
        @(posedge clk);
        #1;
        req = '0;
        for (int c = 0; c < 10 && doneCount == startCount; c++) @(negedge clk);
        checkOutput("t6DoneSeen", 32'(doneCount - startCount), 32'd1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("t6IdleBusy",  32'(busy),  32'd0);
            checkOutput("t6IdleGrant", 32'(grant), 32'd0);
        end
        checkOutput("t6SumHeld", 32'(sum), 32'd397);

        // T5: reset in EXEC (Ptr=3 would pick 3; after reset Ptr=0 picks 1)
        setOperands(1, 24'd11, 24'd22);
        setOperands(3, 24'd300, 24'd400);
        @(posedge clk);
        #1;
        req = 4'b1010;
        @(posedge clk);
        #1;
        checkOutput("t5GrantBeforeReset", 32'(grant), 32'h8);
        #1 rstN = 1'b0;
        #1;
        checkAllZero("t5AsyncReset");
        @(posedge clk);
        #1 rstN = 1'b1;
        pushExp(1, 24'd33, 1'b0);
        pushExp(3, 24'd700, 1'b0);
        applyStimulus(4'b1010, 1, 30);

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
